// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the hart-to-memory-controller arbiter:
// atomic funct5 codes for LR/SC, hart-index width derivation and FSM states.
package mem_bus_arbiter_pkg;

    // funct7[6:2] codes of the reservation instructions (A extension encoding)
    localparam logic [4:0] AMO_LR = 5'b00010;
    localparam logic [4:0] AMO_SC = 5'b00011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit index so ports never collapse to zero width
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning upward from ptr+1 and wrapping, so the last winner (ptr) has
// lowest priority.
module mem_bus_arbiter_rr_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter  int N_IDS = 2,
    localparam int ID_W  = id_width(N_IDS)
) (
    input  logic [N_IDS-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt,
    output logic             vld
);

    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit is written last and wins
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = N_IDS; i >= 1; i--) begin
            idx = ID_W'((int'(ptr) + i) % N_IDS);
            if (req[idx]) begin
                gnt = idx;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between N_IDS hart data ports and one atomic-capable
// memory controller port. The granted hart's request is forwarded until the
// controller acks; ack and read data are routed back to that hart.
// Optional feature macro: ARB_LR_LOCK_EN -- after an acked LR, only the
// reserving hart may use the bus until its SC is acked or LOCK_CYCLES idle
// cycles elapse.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter  int N_IDS       = 2,
    parameter  int LOCK_CYCLES = 64,
    localparam int ID_W        = id_width(N_IDS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_IDS-1:0]     i_bus_en,
    input  logic [N_IDS-1:0]     i_wr_en,
    input  logic [32*N_IDS-1:0]  i_wr_data,
    input  logic [32*N_IDS-1:0]  i_addr,
    input  logic [4*N_IDS-1:0]   i_byte_en,
    input  logic [N_IDS-1:0]     i_atomic,
    input  logic [7*N_IDS-1:0]   i_operation,
    output logic [N_IDS-1:0]     o_ack,
    output logic [31:0]          o_rd_data,
    output logic                 o_bus_en,
    output logic                 o_wr_en,
    output logic [31:0]          o_wr_data,
    output logic [31:0]          o_addr,
    output logic [3:0]           o_byte_en,
    output logic                 o_atomic,
    output logic [6:0]           o_operation,
    output logic [ID_W-1:0]      o_id,
    input  logic                 i_ack,
    input  logic [31:0]          i_rd_data
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_IDS-1:0] eligible;
    logic [ID_W-1:0]  pick;
    logic             pick_vld;
    logic             ack_fire;

    logic             wr_en_a     [N_IDS];
    logic [31:0]      wr_data_a   [N_IDS];
    logic [31:0]      addr_a      [N_IDS];
    logic [3:0]       byte_en_a   [N_IDS];
    logic             atomic_a    [N_IDS];
    logic [6:0]       operation_a [N_IDS];

    logic             sel_wr_en;
    logic [31:0]      sel_wr_data;
    logic [31:0]      sel_addr;
    logic [3:0]       sel_byte_en;
    logic             sel_atomic;
    logic [6:0]       sel_operation;

    for (genvar k = 0; k < N_IDS; k++) begin : g_unpack
        assign wr_en_a[k]     = i_wr_en[k];
        assign wr_data_a[k]   = i_wr_data[32*k +: 32];
        assign addr_a[k]      = i_addr[32*k +: 32];
        assign byte_en_a[k]   = i_byte_en[4*k +: 4];
        assign atomic_a[k]    = i_atomic[k];
        assign operation_a[k] = i_operation[7*k +: 7];
    end

    // The forwarded request is a live mux of the granted hart, so it stays
    // stable for as long as that hart holds its fields (including AMO RMW).
    assign sel_wr_en     = wr_en_a[grant];
    assign sel_wr_data   = wr_data_a[grant];
    assign sel_addr      = addr_a[grant];
    assign sel_byte_en   = byte_en_a[grant];
    assign sel_atomic    = atomic_a[grant];
    assign sel_operation = operation_a[grant];

    assign ack_fire = (state == ST_BUSY) && i_ack;

`ifdef ARB_LR_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [CNT_W-1:0] lock_cnt;
    logic [ID_W-1:0]  lock_id;
    logic [N_IDS-1:0] lock_mask;
    logic             locked;
    logic             lr_done;
    logic             sc_done;

    // A nonzero countdown is the lock itself; reaching zero releases it
    assign locked  = (lock_cnt != '0);
    assign lr_done = ack_fire && sel_atomic && (sel_operation[6:2] == AMO_LR);
    assign sc_done = ack_fire && sel_atomic && (sel_operation[6:2] == AMO_SC)
                     && (grant == lock_id);

    // One-hot of the reserving hart, used to mask everyone else while locked
    always_comb begin
        lock_mask          = '0;
        lock_mask[lock_id] = 1'b1;
    end

    assign eligible = locked ? (i_bus_en & lock_mask) : i_bus_en;

    // Reservation tracker: LR (re)loads, matching SC clears, idle cycles count down
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lock_cnt <= '0;
            lock_id  <= '0;
        end else if (lr_done) begin
            lock_cnt <= CNT_W'(LOCK_CYCLES);
            lock_id  <= grant;
        end else if (sc_done) begin
            lock_cnt <= '0;
        end else if ((state == ST_IDLE) && locked) begin
            lock_cnt <= lock_cnt - 1'b1;
        end
    end
`else
    logic unused_lock_cfg;

    assign unused_lock_cfg = (LOCK_CYCLES != 0);
    assign eligible        = i_bus_en;
`endif

    mem_bus_arbiter_rr_picker #(
        .N_IDS (N_IDS)
    ) u_picker (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (pick),
        .vld (pick_vld)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the arbitration winner; it also becomes the lowest-priority hart next round
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            grant  <= '0;
            rr_ptr <= ID_W'(N_IDS - 1);
        end else if ((state == ST_IDLE) && pick_vld) begin
            grant  <= pick;
            rr_ptr <= pick;
        end
    end

    // Next state: arbitrate in IDLE, return to IDLE on controller ack
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_BUSY;
            ST_BUSY: if (i_ack)    state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: forward the granted request while BUSY, pass the ack straight back
    always_comb begin
        o_bus_en    = 1'b0;
        o_wr_en     = 1'b0;
        o_wr_data   = '0;
        o_addr      = '0;
        o_byte_en   = '0;
        o_atomic    = 1'b0;
        o_operation = '0;
        o_id        = '0;
        o_ack       = '0;
        o_rd_data   = '0;
        if (state == ST_BUSY) begin
            // Dropped in the ack cycle so the controller never sees a stale request
            o_bus_en    = !i_ack;
            o_wr_en     = sel_wr_en;
            o_wr_data   = sel_wr_data;
            o_addr      = sel_addr;
            o_byte_en   = sel_byte_en;
            o_atomic    = sel_atomic;
            o_operation = sel_operation;
            o_id        = grant;
            if (ack_fire) begin
                o_ack[grant] = 1'b1;
                o_rd_data    = i_rd_data;
            end
        end
    end

endmodule
